// File: rtl/ft_pkg.sv
// Shared types and core-select constants for the duplex FT recovery sequencer.
package ft_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        VRD   = 3'd3,
        VCMP  = 3'd4,
        PC    = 3'd5,
        DONE  = 3'd6
    } rec_state_e;

    localparam logic CORE_A = 1'b0;
    localparam logic CORE_B = 1'b1;

    // The faulty (target) core is whichever core is not the healthy source.
    function automatic logic is_target(input logic core, input logic src);
        return (core != src);
    endfunction

endpackage

// File: rtl/ft_recovery_sequencer.sv
// Copies the healthy core's register file and PC into the faulty core after a recover pulse.
// Optional read-back verify with bounded retry is enabled by defining FT_RECOVERY_VERIFY_EN.
module ft_recovery_sequencer
    import ft_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  src_sel_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_we_a_o,
    output logic                  rf_we_b_o,
    input  logic [DATA_WIDTH-1:0] pc_a_i,
    input  logic [DATA_WIDTH-1:0] pc_b_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_we_a_o,
    output logic                  pc_we_b_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    if ((2 ** ADDR_WIDTH) < NUM_REGS || MAX_RETRY < 0) begin : g_cfg_err
        $error("ft_recovery_sequencer: ADDR_WIDTH too small for NUM_REGS or negative MAX_RETRY");
    end

    rec_state_e            state_r;
    rec_state_e            state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  src_r;
    logic                  addr_last_s;
    logic                  advance_s;
    logic [DATA_WIDTH-1:0] src_rdata_s;
    logic [DATA_WIDTH-1:0] src_pc_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    assign addr_last_s = (addr_r == ADDR_LAST);
    assign src_rdata_s = (src_r == CORE_B) ? rf_rdata_b_i : rf_rdata_a_i;
    assign src_pc_s    = (src_r == CORE_B) ? pc_b_i : pc_a_i;

`ifdef FT_RECOVERY_VERIFY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0]    retry_r;
    logic [DATA_WIDTH-1:0] data_q_r;
    logic [DATA_WIDTH-1:0] tgt_rdata_s;
    logic                  match_s;
    logic                  give_up_s;
    logic                  fail_r;

    assign tgt_rdata_s = (src_r == CORE_B) ? rf_rdata_a_i : rf_rdata_b_i;
    assign match_s     = (tgt_rdata_s == data_q_r);
    assign advance_s   = (state_r == VCMP) && match_s;
    assign give_up_s   = (state_r == VCMP) && !match_s && (retry_r == RETRY_W'(MAX_RETRY));
    // A retry replays the captured word; the source port is not re-read.
    assign wdata_s     = (retry_r == {RETRY_W{1'b0}}) ? src_rdata_s : data_q_r;
    assign fail_o      = fail_r;
`else
    assign advance_s   = (state_r == WRITE);
    assign wdata_s     = src_rdata_s;
    assign fail_o      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Copy address, latched source core and verify bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_r   <= ADDR_FIRST;
            src_r    <= CORE_A;
`ifdef FT_RECOVERY_VERIFY_EN
            retry_r  <= {RETRY_W{1'b0}};
            data_q_r <= {DATA_WIDTH{1'b0}};
            fail_r   <= 1'b0;
`endif
        end else if (state_r == IDLE && start_i) begin
            addr_r   <= ADDR_FIRST;
            src_r    <= src_sel_i;
`ifdef FT_RECOVERY_VERIFY_EN
            retry_r  <= {RETRY_W{1'b0}};
            fail_r   <= 1'b0;
`endif
        end else begin
            if (advance_s && !addr_last_s) begin
                addr_r <= addr_r + ADDR_FIRST;
            end
`ifdef FT_RECOVERY_VERIFY_EN
            if (state_r == WRITE && retry_r == {RETRY_W{1'b0}}) begin
                data_q_r <= src_rdata_s;
            end
            if (advance_s) begin
                retry_r <= {RETRY_W{1'b0}};
            end else if (state_r == VCMP && !give_up_s) begin
                retry_r <= retry_r + RETRY_W'(1);
            end
            if (give_up_s) begin
                fail_r <= 1'b1;
            end
`endif
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start_i ? READ : IDLE;
            READ:    state_s = WRITE;
`ifdef FT_RECOVERY_VERIFY_EN
            WRITE:   state_s = VRD;
            VRD:     state_s = VCMP;
            VCMP: begin
                if (match_s) begin
                    state_s = addr_last_s ? PC : READ;
                end else if (give_up_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
`else
            WRITE:   state_s = addr_last_s ? PC : READ;
`endif
            PC:      state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the registered state only; enables never depend on inputs
    always_comb begin
        rf_raddr_o = {ADDR_WIDTH{1'b0}};
        rf_waddr_o = {ADDR_WIDTH{1'b0}};
        rf_wdata_o = {DATA_WIDTH{1'b0}};
        rf_we_a_o  = 1'b0;
        rf_we_b_o  = 1'b0;
        pc_o       = {DATA_WIDTH{1'b0}};
        pc_we_a_o  = 1'b0;
        pc_we_b_o  = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_r != IDLE);
        case (state_r)
            READ:    rf_raddr_o = addr_r;
            WRITE: begin
                rf_waddr_o = addr_r;
                rf_wdata_o = wdata_s;
                rf_we_a_o  = is_target(CORE_A, src_r);
                rf_we_b_o  = is_target(CORE_B, src_r);
            end
`ifdef FT_RECOVERY_VERIFY_EN
            VRD:     rf_raddr_o = addr_r;
`endif
            PC: begin
                pc_o      = src_pc_s;
                pc_we_a_o = is_target(CORE_A, src_r);
                pc_we_b_o = is_target(CORE_B, src_r);
            end
            DONE:    done_o = 1'b1;
            default: done_o = 1'b0;
        endcase
    end

endmodule
